// File: rtl/csr_file.sv
// csr_file: CSR file for the WB stage: combinational reads, committed writes, exception entry/ertn, interrupts.
// Define CSR_TIMER_EN to build the countdown timer (writable TID, TCFG/TVAL/TICLR and timer interrupt IS[11]).
module csr_file #(
  parameter logic [31:0] COREID  = 32'h0,
  parameter int          TIMER_W = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csr_re,
  input  logic [13:0] csr_num,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_ex,
  input  logic        ertn_flush,
  input  logic [31:0] wb_pc,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_vaddr,
  input  logic [7:0]  hw_int_in,
  output logic [31:0] csr_rvalue,
  output logic [31:0] ex_entry,
  output logic [31:0] era_pc,
  output logic        has_int
);
  localparam logic [13:0] A_CRMD  = 14'h00, A_PRMD  = 14'h01, A_ECFG  = 14'h04, A_ESTAT = 14'h05;
  localparam logic [13:0] A_ERA   = 14'h06, A_BADV  = 14'h07, A_EENTRY = 14'h0C;
  localparam logic [13:0] A_SAVE0 = 14'h30, A_SAVE1 = 14'h31, A_SAVE2 = 14'h32, A_SAVE3 = 14'h33;
  localparam logic [13:0] A_TID   = 14'h40, A_TCFG  = 14'h41, A_TVAL  = 14'h42, A_TICLR = 14'h44;
  localparam logic [5:0]  EC_ADE = 6'h08, EC_ALE = 6'h09, EC_TLBR = 6'h3F;
  localparam logic [5:0]  EC_PIL = 6'h01, EC_PIS = 6'h02, EC_PIF = 6'h03, EC_PME = 6'h04, EC_PPI = 6'h07;

  logic [3:0]       crmd_q, crmd_d;
  logic [2:0]       prmd_q, prmd_d;
  logic [12:0]      lie_q, lie_d;
  logic [1:0]       is_sw_q, is_sw_d;
  logic [7:0]       is_hw_q;
  logic [5:0]       ecode_q, ecode_d;
  logic [8:0]       esub_q, esub_d;
  logic [31:0]      era_q, era_d, badv_q, badv_d;
  logic [25:0]      eentry_q, eentry_d;
  logic [3:0][31:0] save_q, save_d;
  logic             ti;
  logic [31:0]      tid_rd, tcfg_rd, tval_rd;
  logic [31:0]      wmerged;
  logic [12:0]      estat_is;
  logic             wr_en, vaddr_ex;
  logic             unused_csr_re;

  assign unused_csr_re = csr_re;
  // Writes lose to exception entry and ertn in the same cycle.
  assign wr_en    = csr_we & ~wb_ex & ~ertn_flush;
  assign wmerged  = (csr_rvalue & ~csr_wmask) | (csr_wvalue & csr_wmask);
  assign estat_is = {1'b0, ti, 1'b0, is_hw_q, is_sw_q};
  assign vaddr_ex = (wb_ecode == EC_ALE) || (wb_ecode == EC_TLBR) || (wb_ecode == EC_PIL) ||
                    (wb_ecode == EC_PIS) || (wb_ecode == EC_PIF) || (wb_ecode == EC_PME) ||
                    (wb_ecode == EC_PPI);

  always_comb begin
    csr_rvalue = 32'h0;
    case (csr_num)
      A_CRMD:   csr_rvalue = {28'h0, crmd_q};
      A_PRMD:   csr_rvalue = {29'h0, prmd_q};
      A_ECFG:   csr_rvalue = {19'h0, lie_q};
      A_ESTAT:  csr_rvalue = {1'b0, esub_q, ecode_q, 3'h0, estat_is};
      A_ERA:    csr_rvalue = era_q;
      A_BADV:   csr_rvalue = badv_q;
      A_EENTRY: csr_rvalue = {eentry_q, 6'h0};
      A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3: csr_rvalue = save_q[csr_num[1:0]];
      A_TID:    csr_rvalue = tid_rd;
      A_TCFG:   csr_rvalue = tcfg_rd;
      A_TVAL:   csr_rvalue = tval_rd;
      default:  csr_rvalue = 32'h0;
    endcase
  end

  always_comb begin
    crmd_d   = crmd_q;
    prmd_d   = prmd_q;
    lie_d    = lie_q;
    is_sw_d  = is_sw_q;
    ecode_d  = ecode_q;
    esub_d   = esub_q;
    era_d    = era_q;
    badv_d   = badv_q;
    eentry_d = eentry_q;
    save_d   = save_q;
    if (wb_ex) begin
      prmd_d  = crmd_q[2:0];
      crmd_d  = {crmd_q[3], 3'b000};
      ecode_d = wb_ecode;
      esub_d  = wb_esubcode;
      era_d   = wb_pc;
      if (wb_ecode == EC_ADE) badv_d = wb_pc;
      else if (vaddr_ex)      badv_d = wb_vaddr;
    end else if (ertn_flush) begin
      crmd_d = {crmd_q[3], prmd_q};
    end else if (wr_en) begin
      case (csr_num)
        A_CRMD:   crmd_d   = wmerged[3:0];
        A_PRMD:   prmd_d   = wmerged[2:0];
        A_ECFG:   lie_d    = wmerged[12:0];
        A_ESTAT:  is_sw_d  = wmerged[1:0];
        A_ERA:    era_d    = wmerged;
        A_BADV:   badv_d   = wmerged;
        A_EENTRY: eentry_d = wmerged[31:6];
        A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3: save_d[csr_num[1:0]] = wmerged;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crmd_q   <= 4'h8;
      prmd_q   <= '0;
      lie_q    <= '0;
      is_sw_q  <= '0;
      is_hw_q  <= '0;
      ecode_q  <= '0;
      esub_q   <= '0;
      era_q    <= '0;
      badv_q   <= '0;
      eentry_q <= '0;
      save_q   <= '0;
    end else begin
      crmd_q   <= crmd_d;
      prmd_q   <= prmd_d;
      lie_q    <= lie_d;
      is_sw_q  <= is_sw_d;
      is_hw_q  <= hw_int_in;
      ecode_q  <= ecode_d;
      esub_q   <= esub_d;
      era_q    <= era_d;
      badv_q   <= badv_d;
      eentry_q <= eentry_d;
      save_q   <= save_d;
    end
  end

`ifdef CSR_TIMER_EN
  localparam logic [TIMER_W-1:0] TV_ONE = TIMER_W'(1);
  logic [31:0]        tid_q, tid_d, tcfg_q, tcfg_d;
  logic [TIMER_W-1:0] tval_q, tval_d;
  logic               ti_q, ti_d;
  logic [31:0]        load_new, load_cur;
  logic               tcfg_wr, ticlr_wr;

  assign load_new = {wmerged[31:2], 2'b00};
  assign load_cur = {tcfg_q[31:2], 2'b00};
  assign tcfg_wr  = wr_en && (csr_num == A_TCFG);
  assign ticlr_wr = wr_en && (csr_num == A_TICLR) && csr_wmask[0] && csr_wvalue[0];

  always_comb begin
    tid_d  = tid_q;
    tcfg_d = tcfg_q;
    tval_d = tval_q;
    ti_d   = ti_q;
    if (wr_en && (csr_num == A_TID)) tid_d = wmerged;
    if (tcfg_wr) tcfg_d = wmerged;
    // A fresh enable reloads the counter ahead of any decrement.
    if (tcfg_wr && wmerged[0]) begin
      tval_d = load_new[TIMER_W-1:0];
    end else if (tcfg_q[0]) begin
      if (tval_q != '0)   tval_d = tval_q - TV_ONE;
      else if (tcfg_q[1]) tval_d = load_cur[TIMER_W-1:0];
    end
    if (tcfg_q[0] && (tval_q == TV_ONE)) ti_d = 1'b1;
    else if (ticlr_wr)                   ti_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tid_q  <= COREID;
      tcfg_q <= '0;
      tval_q <= '0;
      ti_q   <= 1'b0;
    end else begin
      tid_q  <= tid_d;
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
      ti_q   <= ti_d;
    end
  end

  assign ti      = ti_q;
  assign tid_rd  = tid_q;
  assign tcfg_rd = tcfg_q;
  assign tval_rd = 32'(tval_q);
`else
  localparam int unused_timer_w = TIMER_W;
  assign ti      = 1'b0;
  assign tid_rd  = COREID;
  assign tcfg_rd = 32'h0;
  assign tval_rd = 32'h0;
`endif

  assign ex_entry = {eentry_q, 6'h0};
  assign era_pc   = era_q;
  assign has_int  = crmd_q[2] & (|(estat_is & lie_q));
endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus randomized traffic against an array-based CSR model.
module tb_csr_file;
  localparam logic [31:0] COREID = 32'h0000_00A5;

  logic        clk = 1'b0;
  logic        resetn;
  logic        csr_re;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask, csr_wvalue;
  logic        wb_ex, ertn_flush;
  logic [31:0] wb_pc, wb_vaddr;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [7:0]  hw_int_in;
  logic [31:0] csr_rvalue, ex_entry, era_pc;
  logic        has_int;

  int total = 0;
  int bad   = 0;

  csr_file #(.COREID(COREID), .TIMER_W(32)) dut (
    .clk(clk), .resetn(resetn), .csr_re(csr_re), .csr_num(csr_num), .csr_we(csr_we),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
    .wb_pc(wb_pc), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_vaddr(wb_vaddr),
    .hw_int_in(hw_int_in), .csr_rvalue(csr_rvalue), .ex_entry(ex_entry), .era_pc(era_pc),
    .has_int(has_int)
  );

  always #50 clk = ~clk;

  // Reference model: one 32-bit word per CSR address, plus the timer count.
  logic [31:0] mr [0:68];
  logic [31:0] m_tval;
  logic [13:0] alist [0:17] = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h07, 14'h0C, 14'h30,
                                14'h31, 14'h32, 14'h33, 14'h40, 14'h41, 14'h42, 14'h44, 14'h02,
                                14'h03, 14'h100};
  logic [5:0]  eclist [0:10] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h07, 6'h08, 6'h09,
                                 6'h0B, 6'h3F, 6'h0C};

  function automatic logic [31:0] wr_mask(input logic [13:0] a);
    case (a)
      14'h00: return 32'h0000_000F;
      14'h01: return 32'h0000_0007;
      14'h04: return 32'h0000_1FFF;
      14'h05: return 32'h0000_0003;
      14'h06, 14'h07: return 32'hFFFF_FFFF;
      14'h0C: return 32'hFFFF_FFC0;
      14'h30, 14'h31, 14'h32, 14'h33: return 32'hFFFF_FFFF;
`ifdef CSR_TIMER_EN
      14'h40, 14'h41: return 32'hFFFF_FFFF;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_rd(input logic [13:0] a);
    if (a > 14'h44) return 32'h0;
    if (a == 14'h42) return m_tval;
    if (a == 14'h44) return 32'h0;
    return mr[a];
  endfunction

  function automatic logic exp_int();
    return mr[0][2] && (|(mr[5][12:0] & mr[4][12:0]));
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= 68; i++) mr[i] = 32'h0;
    mr[0]  = 32'h8;
    mr[64] = COREID;
    m_tval = 32'h0;
  endtask

  // Predict the next state from the driven inputs, clock once, then adopt the prediction.
  task automatic step();
    logic [31:0] nx [0:68];
    logic [31:0] nt, m;
    logic        wr;
`ifdef CSR_TIMER_EN
    logic [31:0] tc;
`endif
    nx = mr;
    nt = m_tval;
    wr = csr_we && !wb_ex && !ertn_flush;
    nx[5][9:2] = hw_int_in;
    if (wb_ex) begin
      nx[1][1:0] = mr[0][1:0];
      nx[1][2]   = mr[0][2];
      nx[0][2:0] = 3'b000;
      nx[5][21:16] = wb_ecode;
      nx[5][30:22] = wb_esubcode;
      nx[6] = wb_pc;
      if (wb_ecode == 6'h08) nx[7] = wb_pc;
      else if (wb_ecode inside {6'h09, 6'h3F, 6'h01, 6'h02, 6'h03, 6'h04, 6'h07}) nx[7] = wb_vaddr;
    end else if (ertn_flush) begin
      nx[0][1:0] = mr[1][1:0];
      nx[0][2]   = mr[1][2];
    end else if (wr && csr_num <= 14'h44) begin
      m = csr_wmask & wr_mask(csr_num);
      nx[csr_num] = (nx[csr_num] & ~m) | (csr_wvalue & m);
    end
`ifdef CSR_TIMER_EN
    tc = mr[65];
    if (wr && csr_num == 14'h41 && nx[65][0]) nt = {nx[65][31:2], 2'b00};
    else if (tc[0]) nt = (m_tval != 0) ? m_tval - 32'd1 : (tc[1] ? {tc[31:2], 2'b00} : 32'd0);
    if (tc[0] && m_tval == 32'd1) nx[5][11] = 1'b1;
    else if (wr && csr_num == 14'h44 && csr_wmask[0] && csr_wvalue[0]) nx[5][11] = 1'b0;
`endif
    @(posedge clk);
    #1;
    mr = nx;
    m_tval = nt;
    csr_we = 1'b0;
    wb_ex = 1'b0;
    ertn_flush = 1'b0;
  endtask

  task automatic drv_write(input logic [13:0] a, input logic [31:0] m, input logic [31:0] v);
    csr_num = a; csr_we = 1'b1; csr_wmask = m; csr_wvalue = v;
    step();
  endtask

  task automatic drv_ex(input logic [5:0] ec, input logic [8:0] sub, input logic [31:0] pc,
                        input logic [31:0] va);
    wb_ex = 1'b1; wb_ecode = ec; wb_esubcode = sub; wb_pc = pc; wb_vaddr = va;
    step();
  endtask

  task automatic drv_idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rd(input logic [13:0] a, output logic [31:0] d);
    csr_num = a;
    #1;
    d = csr_rvalue;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    resetn = 1'b0; csr_re = 1'b0; csr_num = '0; csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
    wb_ex = 1'b0; ertn_flush = 1'b0; wb_pc = '0; wb_ecode = '0; wb_esubcode = '0; wb_vaddr = '0;
    hw_int_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    csr_re = 1'b1;
    rd(14'h00, d);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL reset_crmd got=%h exp=%h", d, 32'h8); end
    rd(14'h06, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_era got=%h exp=0", d); end
    rd(14'h0C, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_eentry got=%h exp=0", d); end
    rd(14'h42, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_tval got=%h exp=0", d); end
    rd(14'h40, d);
    total++; if (d !== COREID) begin bad++; $display("FAIL reset_tid got=%h exp=%h", d, COREID); end
    for (int i = 0; i < 18; i++) begin
      rd(alist[i], d);
      total++;
      if (d !== exp_rd(alist[i])) begin
        bad++; $display("FAIL reset_rd addr=%h got=%h exp=%h", alist[i], d, exp_rd(alist[i]));
      end
    end
    total++; if (has_int !== 1'b0) begin bad++; $display("FAIL reset_has_int got=%b exp=0", has_int); end
    total++; if (ex_entry !== 32'h0) begin bad++; $display("FAIL reset_ex_entry got=%h exp=0", ex_entry); end
    total++; if (era_pc !== 32'h0) begin bad++; $display("FAIL reset_era_pc got=%h exp=0", era_pc); end
  endtask

  task automatic test_exception();
    logic [31:0] d;
    drv_write(14'h00, 32'hF, 32'hE);
    drv_write(14'h0C, 32'hFFFF_FFFF, 32'h1C00_8000);
    drv_ex(6'h09, 9'h0, 32'h1C00_0100, 32'h0000_0003);
    total++; if (ex_entry !== 32'h1C00_8000) begin bad++; $display("FAIL ex_entry got=%h exp=%h", ex_entry, 32'h1C00_8000); end
    total++; if (era_pc !== 32'h1C00_0100) begin bad++; $display("FAIL ex_era got=%h exp=%h", era_pc, 32'h1C00_0100); end
    rd(14'h07, d);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL ex_badv got=%h exp=3", d); end
    rd(14'h05, d);
    total++; if (d[21:16] !== 6'h09) begin bad++; $display("FAIL ex_ecode got=%h exp=09", d[21:16]); end
    total++; if (d !== exp_rd(14'h05)) begin bad++; $display("FAIL ex_estat got=%h exp=%h", d, exp_rd(14'h05)); end
    rd(14'h00, d);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL ex_crmd got=%h exp=8", d); end
    rd(14'h01, d);
    total++; if (d !== 32'h6) begin bad++; $display("FAIL ex_prmd got=%h exp=6", d); end
  endtask

  task automatic test_ertn();
    logic [31:0] d;
    drv_write(14'h00, 32'hF, 32'hF);
    drv_ex(6'h0B, 9'h0, 32'h1C00_0200, 32'h0);
    rd(14'h00, d);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL ertn_pre_crmd got=%h exp=8", d); end
    ertn_flush = 1'b1;
    step();
    rd(14'h00, d);
    total++; if (d !== 32'hF) begin bad++; $display("FAIL ertn_crmd got=%h exp=f", d); end
    rd(14'h01, d);
    total++; if (d !== 32'h7) begin bad++; $display("FAIL ertn_prmd got=%h exp=7", d); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    drv_write(14'h30, 32'hFFFF_FFFF, 32'h1111);
    csr_num = 14'h30; csr_we = 1'b1; csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'hDEAD;
    wb_ex = 1'b1; wb_ecode = 6'h0B; wb_esubcode = 9'h0; wb_pc = 32'h1C00_0300; wb_vaddr = 32'h0;
    step();
    rd(14'h30, d);
    total++; if (d !== 32'h1111) begin bad++; $display("FAIL prio_save0 got=%h exp=1111", d); end
    drv_write(14'h00, 32'hF, 32'hF);
    wb_ex = 1'b1; ertn_flush = 1'b1; wb_ecode = 6'h0B; wb_pc = 32'h1C00_0400;
    step();
    rd(14'h00, d);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL prio_ex_ertn_crmd got=%h exp=8", d); end
    rd(14'h01, d);
    total++; if (d !== 32'h7) begin bad++; $display("FAIL prio_ex_ertn_prmd got=%h exp=7", d); end
    total++; if (era_pc !== 32'h1C00_0400) begin bad++; $display("FAIL prio_ex_ertn_era got=%h exp=%h", era_pc, 32'h1C00_0400); end
  endtask

  task automatic test_badv();
    logic [31:0] d;
    drv_ex(6'h08, 9'h1, 32'h0000_2000, 32'h0000_3000);
    rd(14'h07, d);
    total++; if (d !== 32'h2000) begin bad++; $display("FAIL badv_ade got=%h exp=2000", d); end
    drv_ex(6'h0B, 9'h0, 32'h0000_4000, 32'h0000_5000);
    rd(14'h07, d);
    total++; if (d !== 32'h2000) begin bad++; $display("FAIL badv_hold got=%h exp=2000", d); end
    drv_ex(6'h3F, 9'h0, 32'h0000_6000, 32'h0000_7000);
    rd(14'h07, d);
    total++; if (d !== 32'h7000) begin bad++; $display("FAIL badv_tlbr got=%h exp=7000", d); end
    rd(14'h05, d);
    total++; if (d[30:22] !== 9'h0 || d[21:16] !== 6'h3F) begin bad++; $display("FAIL badv_estat got=%h exp=%h", d, exp_rd(14'h05)); end
  endtask

  task automatic test_hwint();
    logic [31:0] d;
    drv_write(14'h04, 32'hFFFF_FFFF, 32'h4);
    drv_write(14'h00, 32'h4, 32'h4);
    hw_int_in = 8'h01;
    total++; if (has_int !== 1'b0) begin bad++; $display("FAIL hwint_pre got=%b exp=0", has_int); end
    step();
    rd(14'h05, d);
    total++; if (d[2] !== 1'b1) begin bad++; $display("FAIL hwint_is2 got=%b exp=1", d[2]); end
    total++; if (has_int !== 1'b1) begin bad++; $display("FAIL hwint_has_int got=%b exp=1", has_int); end
    drv_write(14'h00, 32'h4, 32'h0);
    total++; if (has_int !== 1'b0) begin bad++; $display("FAIL hwint_ie0 got=%b exp=0", has_int); end
    hw_int_in = 8'h00;
    step();
  endtask

`ifdef CSR_TIMER_EN
  task automatic test_timer();
    logic [31:0] d, frozen;
    logic [31:0] seq [0:5] = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd4};
    drv_write(14'h04, 32'hFFFF_FFFF, 32'h800);
    drv_write(14'h00, 32'h4, 32'h4);
    drv_write(14'h41, 32'hFFFF_FFFF, 32'h7);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) drv_idle(1);
      rd(14'h42, d);
      total++; if (d !== seq[i]) begin bad++; $display("FAIL timer_tval i=%0d got=%h exp=%h", i, d, seq[i]); end
      rd(14'h05, d);
      total++; if (d[11] !== (i >= 4)) begin bad++; $display("FAIL timer_ti i=%0d got=%b exp=%b", i, d[11], i >= 4); end
      total++; if (has_int !== (i >= 4)) begin bad++; $display("FAIL timer_has_int i=%0d got=%b exp=%b", i, has_int, i >= 4); end
    end
    drv_write(14'h44, 32'h1, 32'h1);
    rd(14'h05, d);
    total++; if (d[11] !== 1'b0) begin bad++; $display("FAIL ticlr_ti got=%b exp=0", d[11]); end
    total++; if (has_int !== 1'b0) begin bad++; $display("FAIL ticlr_has_int got=%b exp=0", has_int); end
    rd(14'h44, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL ticlr_read got=%h exp=0", d); end
    drv_write(14'h41, 32'hFFFF_FFFF, 32'h0);
    rd(14'h42, frozen);
    total++; if (frozen !== exp_rd(14'h42)) begin bad++; $display("FAIL timer_dis got=%h exp=%h", frozen, exp_rd(14'h42)); end
    drv_idle(3);
    rd(14'h42, d);
    total++; if (d !== 32'd2) begin bad++; $display("FAIL timer_frozen got=%h exp=2", d); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] d;
    drv_write(14'h41, 32'hFFFF_FFFF, 32'h41);
    drv_idle(3);
    #10;
    resetn = 1'b0;
    model_reset();
    rd(14'h42, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rstmid_tval got=%h exp=0", d); end
    rd(14'h41, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rstmid_tcfg got=%h exp=0", d); end
    rd(14'h05, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rstmid_estat got=%h exp=0", d); end
    rd(14'h00, d);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL rstmid_crmd got=%h exp=8", d); end
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [13:0] a;
    int op;
    for (int n = 0; n < 400; n++) begin
      hw_int_in = 8'($urandom);
      op = $urandom_range(0, 99);
      a = ($urandom_range(0, 9) == 0) ? 14'($urandom) : alist[$urandom_range(0, 17)];
      if (op < 70) begin
        csr_num = a; csr_we = 1'b1;
        csr_wmask = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom;
        csr_wvalue = $urandom;
        if (a == 14'h41) csr_wvalue = csr_wvalue & 32'h3F;
      end else if (op < 78) begin
        wb_ex = 1'b1; wb_ecode = eclist[$urandom_range(0, 10)]; wb_esubcode = 9'($urandom);
        wb_pc = $urandom; wb_vaddr = $urandom;
        csr_num = a; csr_we = $urandom_range(0, 1) ? 1'b1 : 1'b0;
        csr_wmask = $urandom; csr_wvalue = $urandom;
      end else if (op < 84) begin
        ertn_flush = 1'b1;
      end
      step();
      a = alist[$urandom_range(0, 17)];
      rd(a, d);
      total++; if (d !== exp_rd(a)) begin bad++; $display("FAIL rand_rd n=%0d addr=%h got=%h exp=%h", n, a, d, exp_rd(a)); end
      total++; if (has_int !== exp_int()) begin bad++; $display("FAIL rand_has_int n=%0d got=%b exp=%b", n, has_int, exp_int()); end
      total++; if (ex_entry !== mr[12]) begin bad++; $display("FAIL rand_ex_entry n=%0d got=%h exp=%h", n, ex_entry, mr[12]); end
      total++; if (era_pc !== mr[6]) begin bad++; $display("FAIL rand_era n=%0d got=%h exp=%h", n, era_pc, mr[6]); end
    end
  endtask

  initial begin
    test_reset();
    test_exception();
    test_ertn();
    test_priority();
    test_badv();
    test_hwint();
`ifdef CSR_TIMER_EN
    test_timer();
`endif
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Control/status register file answering the WB stage's CSR and exception interface.
- Reads: combinational, returns csr_rvalue for WB's csr_num.
- Writes, exception entry and ertn return: committed at posedge clk.
- Also provides exception/ertn redirect targets to IF, an interrupt request to ID, and a countdown timer.

Parameters:
COREID, 32'h0, reset value of TID
TIMER_W, 32, width of TCFG.InitVal+2 / TVAL counter (≤32)

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
csr_re  in  1  WB reads a CSR this cycle
csr_num  in  14  CSR address
csr_we  in  1  WB writes CSR
csr_wmask  in  32  bit write mask
csr_wvalue  in  32  write data
wb_ex  in  1  exception commits in WB
ertn_flush  in  1  ertn commits in WB
wb_pc  in  32  PC of WB instruction
wb_ecode  in  6  exception code
wb_esubcode  in  9  exception subcode
wb_vaddr  in  32  faulting data vaddr
hw_int_in  in  8  external interrupt lines
csr_rvalue  out  32  read data (combinational)
ex_entry  out  32  EENTRY value (exception target)
era_pc  out  32  ERA value (ertn target)
has_int  out  1  enabled pending interrupt

Behaviour:
- Registers/addresses: CRMD 0x0 {DA[3],IE[2],PLV[1:0]}; PRMD 0x1 {PIE[2],PPLV[1:0]}; ECFG 0x4 {LIE[12:0]}; ESTAT 0x5 {EsubCode[30:22],Ecode[21:16],IS[12:0]}; ERA 0x6; BADV 0x7; EENTRY 0xC {VA[31:6]}; SAVE0-3 0x30-0x33; TID 0x40; TCFG 0x41 {InitVal[31:2],Periodic[1],En[0]}; TVAL 0x42 (RO); TICLR 0x44 (reads 0).
- Reset (async on resetn low):
  - CRMD=32'h8; TID=COREID; all other CSRs 0.
  - Hence ex_entry=0, era_pc=0, has_int=0.
- Read: csr_rvalue = selected register (unimplemented bits 0); unknown csr_num -> 0. Zero-latency, independent of csr_re.
- Write:
  - Takes effect at posedge when csr_we & ~wb_ex: new = (old & ~wmask) | (wvalue & wmask), writable fields only.
  - ESTAT: only IS[1:0] writable.
  - TVAL: not writable.
- Priority each cycle: wb_ex > ertn_flush > csr_we. Lower-priority CSR updates are dropped; timer and IS sampling still run.
- Exception entry (wb_ex):
  - PRMD.PPLV<=CRMD.PLV, PIE<=CRMD.IE; CRMD.PLV<=0, IE<=0.
  - ESTAT.Ecode<=wb_ecode, EsubCode<=wb_esubcode; ERA<=wb_pc.
  - BADV<=wb_pc if ecode=ADE; BADV<=wb_vaddr if ecode ∈ {ALE,TLBR,PIL,PIS,PIF,PME,PPI}; else unchanged.
- ertn_flush: CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PIE.
- IS update:
  - IS[9:2] <= hw_int_in every cycle (one-cycle sample delay).
  - IS[10] reserved, reads 0.
  - IS[11] = TI (timer interrupt).
- has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), combinational from registered state.
- Timer:
  - TCFG write with new En=1 loads TVAL<={InitVal,2'b00}; this has precedence over decrement that cycle.
  - Otherwise, if En: TVAL!=0 -> TVAL-1; TVAL==0 & Periodic -> reload {InitVal,2'b00}; TVAL==0 & ~Periodic -> hold 0.
  - TI set in the cycle En & TVAL==1 (1->0 transition).
  - TICLR write with wmask[0]&wvalue[0] clears TI. Set and clear in the same cycle -> set wins.
  - En=0 freezes TVAL.
- Counter arithmetic is TIMER_W bits wide; upper bits read 0.
- Reset mid-count: TVAL=0, TCFG=0, TI=0 immediately.

Optional Feature:
- Macro: CSR_TIMER_EN.
- Defined: TID/TCFG/TVAL/TICLR and IS[11] behave as above.
- Undefined: no timer logic; TID reads COREID; TCFG/TVAL/TICLR read 0 and ignore writes; IS[11]=0.

Test Plan:
- Reset, then read 0x0 -> 32'h8; read 0x6, 0xC, 0x42 -> 0; has_int=0.
- Write EENTRY wvalue=32'h1C00_8000, wmask=all-ones; next cycle assert wb_ex, ecode=ALE, wb_pc=0x1C00_0100, vaddr=0x0000_0003 -> ex_entry=0x1C00_8000, ERA=0x1C00_0100, BADV=3, ESTAT[21:16]=0x9, CRMD.PLV=0, IE=0, PRMD holds prior PLV/IE.
- CRMD={PLV=3,IE=1}, then wb_ex, then ertn_flush -> CRMD PLV=3, IE=1 restored.
- Same cycle csr_we(SAVE0=0xDEAD) & wb_ex -> SAVE0 unchanged.
- Same cycle wb_ex & ertn_flush -> exception entry only.
- TCFG={InitVal=1,Periodic=1,En=1}: TVAL=4,3,2,1,0,4; TI rises on the cycle TVAL goes 1->0.
  - With ECFG.LIE[11]=1 and CRMD.IE=1 -> has_int=1.
  - TICLR write 1 -> TI=0 and has_int=0 next cycle.
- hw_int_in=8'h01 with LIE[2]=1, IE=1 -> IS[2]=1 and has_int=1 one cycle later; IE=0 -> has_int=0.
